// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared types and constants for the ROM download arbiter
package rom_dl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} dl_state_e;
  localparam int DL_ADDR_W = 16;
  localparam int DL_DATA_W = 8;
  localparam int DL_FIFO_DEPTH = 4;
  localparam int DL_HOLD_CYCLES = 64;
  typedef struct packed {
    logic [DL_ADDR_W-1:0] addr;
    logic [DL_DATA_W-1:0] data;
  } fifo_entry_t;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  localparam int DL_PTR_W = ptr_w(DL_FIFO_DEPTH);
endpackage

// File: rtl/rom_dl_arbiter_fifo.sv
// dl_byte_fifo: synchronous FIFO buffering download writes, accepts a push into a full FIFO when it pops that cycle
module dl_byte_fifo
  import rom_dl_pkg::*;
#(
  parameter int W     = DL_ADDR_W + DL_DATA_W,
  parameter int DEPTH = DL_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         accept
);
  localparam int PW = ptr_w(DEPTH);
  logic [PW:0] wr_q, wr_d, rd_q, rd_d, used;
  logic [W-1:0] mem_q [DEPTH];
  logic do_pop;
  assign used   = wr_q - rd_q;
  assign full   = used == (PW+1)'(DEPTH);
  assign empty  = used == '0;
  assign do_pop = pop && !empty;
  assign accept = push && (!full || do_pop);
  assign dout   = mem_q[rd_q[PW-1:0]];
  // advance pointers on accepted push and on pop
  always_comb begin
    wr_d = wr_q + (PW+1)'(accept);
    rd_d = rd_q + (PW+1)'(do_pop);
  end
  // pointer registers; contents are discarded by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage array, written at the tail
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q[PW-1:0]] <= din;
  end
endmodule

// File: rtl/rom_dl_arbiter.sv
// rom_dl_arbiter: shares the ROM/RAM port between HPS download and CPU reads, sequences core reset; DL_CHECKSUM_EN enables dl_sum
module rom_dl_arbiter
  import rom_dl_pkg::*;
#(
  parameter int ADDR_W      = DL_ADDR_W,
  parameter int DATA_W      = DL_DATA_W,
  parameter int FIFO_DEPTH  = DL_FIFO_DEPTH,
  parameter int HOLD_CYCLES = DL_HOLD_CYCLES
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [DATA_W-1:0] dn_data,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic              cpu_rd_ack,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              core_reset,
  output logic              dl_overflow,
  output logic [ADDR_W:0]   dl_count,
  output logic [DATA_W-1:0] dl_sum
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  dl_state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic dl_prev_q, dl_prev_d, rd_out_q, rd_out_d, dl_overflow_q, dl_overflow_d;
  logic [ADDR_W:0] dl_count_q, dl_count_d;
  logic [ADDR_W+DATA_W-1:0] head;
  logic rise, push_req, push_ok, full, empty, rd_elig, wr_issue, rd_issue;

  dl_byte_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_sys), .rst_n(reset_n), .push(push_req), .pop(wr_issue),
    .din({dn_addr, dn_data}), .dout(head), .full(full), .empty(empty), .accept(push_ok)
  );

  assign rise     = dn_download && !dl_prev_q;
  assign push_req = dn_wr && dn_download && state_q == LOAD;
  // one access per cycle: a full FIFO always wins, otherwise an eligible read goes first
  assign rd_elig  = cpu_rd_req && !rd_out_q;
  assign wr_issue = !empty && (full || !rd_elig);
  assign rd_issue = rd_elig && !wr_issue;

  // memory port and read return path
  always_comb begin
    mem_en      = wr_issue || rd_issue;
    mem_we      = wr_issue;
    mem_addr    = wr_issue ? head[ADDR_W+DATA_W-1:DATA_W] : (rd_issue ? cpu_rd_addr : '0);
    mem_din     = wr_issue ? head[DATA_W-1:0] : '0;
    cpu_rd_ack  = rd_out_q;
    cpu_rd_data = rd_out_q ? mem_dout : '0;
    core_reset  = state_q != IDLE;
    dl_overflow = dl_overflow_q;
    dl_count    = dl_count_q;
  end

  // load sequencing: core stays in reset from download start until the hold window expires
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    case (state_q)
      IDLE:  state_d = rise ? LOAD : IDLE;
      LOAD:  state_d = dn_download ? LOAD : (empty ? HOLD : DRAIN);
      DRAIN: state_d = rise ? LOAD : (empty ? HOLD : DRAIN);
      HOLD: begin
        state_d = rise ? LOAD : (hold_q == HOLD_LAST ? IDLE : HOLD);
        hold_d  = (state_d == HOLD) ? hold_q + HW'(1) : '0;
      end
      default: state_d = HOLD;
    endcase
  end

  // download statistics and read tracking; a full FIFO always pops, so drops only guard against a missing pop
  always_comb begin
    dl_prev_d     = dn_download;
    rd_out_d      = rd_issue;
    dl_overflow_d = rise ? 1'b0 : (dl_overflow_q || (push_req && !push_ok));
    dl_count_d    = rise ? '0 : dl_count_q + (ADDR_W+1)'(push_ok);
  end

  // control registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HOLD;
      hold_q        <= '0;
      dl_prev_q     <= 1'b0;
      rd_out_q      <= 1'b0;
      dl_overflow_q <= 1'b0;
      dl_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      dl_prev_q     <= dl_prev_d;
      rd_out_q      <= rd_out_d;
      dl_overflow_q <= dl_overflow_d;
      dl_count_q    <= dl_count_d;
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [DATA_W-1:0] dl_sum_q, dl_sum_d;
  // running byte sum of accepted download data
  always_comb begin
    dl_sum_d = rise ? '0 : (push_ok ? dl_sum_q + dn_data : dl_sum_q);
    dl_sum   = dl_sum_q;
  end
  // checksum register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) dl_sum_q <= '0;
    else dl_sum_q <= dl_sum_d;
  end
`else
  assign dl_sum = '0;
`endif
endmodule
